// File: rtl/cpu_seq_pkg.sv
// Shared constants for the CPU execution sequencer: FSM encoding and the
// retired-instruction counter width plus its saturating increment.
package cpu_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STEP  = 2'd2;
   localparam logic [1:0] ST_BREAK = 2'd3;

   localparam int                   RETIRED_W   = 16;
   localparam logic [RETIRED_W-1:0] RETIRED_MAX = 16'hFFFF;

   function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
      return (v == RETIRED_MAX) ? v : v + RETIRED_W'(1);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_rise_detect.sv
// Rising-edge detector for a level input synchronous to clk; the history
// register clears on reset.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_q <= 1'b0;
      else       r_q <= d;
   end

   assign rise = d & ~r_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: turns run/step/halt requests and a PC breakpoint into a
// one-cycle commit enable. Optional macro HALT_OPCODE_EN stops on HALT_INSN.
module cpu_run_ctrl
   import cpu_seq_pkg::*;
#(
   parameter int         DIV       = 25000000,
   parameter int         CW        = 25,
   parameter logic [7:0] HALT_INSN = 8'hFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_req,
   input  logic                 step_req,
   input  logic                 halt_req,
   input  logic [7:0]           pc,
   input  logic [7:0]           instruction,
   input  logic [7:0]           bp_addr,
   input  logic                 bp_valid,
   output logic                 pc_en,
   output logic [1:0]           state,
   output logic [RETIRED_W-1:0] retired,
   output logic                 at_bp
);

   localparam logic [CW-1:0] TICK_CNT = CW'(DIV - 1);

   logic [1:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic                 r_pc_en;
   logic                 r_bp_skip;
   logic [RETIRED_W-1:0] r_retired;

   logic       w_rise_run;
   logic       w_rise_step;
   logic       w_tick;
   logic       w_bp_hit;
   logic       w_halt_op;
   logic [1:0] w_next_state;
   logic       w_next_pc_en;
   logic       w_next_skip;
   logic       w_cnt_clr;

   rise_detect u_run_rise (
      .clk   (clk),
      .reset (reset),
      .d     (run_req),
      .rise  (w_rise_run)
   );

   rise_detect u_step_rise (
      .clk   (clk),
      .reset (reset),
      .d     (step_req),
      .rise  (w_rise_step)
   );

`ifdef HALT_OPCODE_EN
   assign w_halt_op = (instruction == HALT_INSN);
`else
   logic w_unused_insn;
   assign w_unused_insn = ^(instruction ^ HALT_INSN);
   assign w_halt_op     = 1'b0;
`endif

   assign w_tick   = (r_state == ST_RUN) && (r_cnt == TICK_CNT);
   assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_bp_skip;

   // The commit decision is made one cycle ahead and registered, so pc_en is
   // high in the cycle after the tick (or in the single STEP cycle).
   always_comb begin
      w_next_state = r_state;
      w_next_pc_en = 1'b0;
      w_next_skip  = r_bp_skip;
      w_cnt_clr    = 1'b0;
      if (halt_req) begin
         w_next_state = ST_IDLE;
         w_next_skip  = 1'b0;
         w_cnt_clr    = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise_run) begin
                  w_next_state = ST_RUN;
                  w_cnt_clr    = 1'b1;
               end else if (w_rise_step) begin
                  w_next_state = ST_STEP;
                  w_next_pc_en = !w_halt_op;
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  if (w_bp_hit) begin
                     w_next_state = ST_BREAK;
                  end else if (w_halt_op) begin
                     w_next_state = ST_IDLE;
                     w_cnt_clr    = 1'b1;
                  end else begin
                     w_next_pc_en = 1'b1;
                     w_next_skip  = 1'b0;
                  end
               end
            end
            ST_STEP: begin
               w_next_state = ST_IDLE;
               w_next_skip  = 1'b0;
            end
            ST_BREAK: begin
               // Resuming sets bp_skip so the breakpointed instruction commits.
               if (w_rise_run) begin
                  w_next_state = ST_RUN;
                  w_next_skip  = 1'b1;
                  w_cnt_clr    = 1'b1;
               end else if (w_rise_step) begin
                  w_next_state = ST_STEP;
                  w_next_pc_en = !w_halt_op;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_pc_en   <= 1'b0;
         r_bp_skip <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_pc_en   <= w_next_pc_en;
         r_bp_skip <= w_next_skip;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               r_cnt <= '0;
      else if (w_cnt_clr || r_state != ST_RUN) r_cnt <= '0;
      else if (w_tick)                         r_cnt <= '0;
      else                                     r_cnt <= r_cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_retired <= '0;
      else if (pc_en) r_retired <= sat_inc(r_retired);
   end

   assign pc_en   = r_pc_en & ~halt_req;
   assign state   = r_state;
   assign retired = r_retired;
   assign at_bp   = (r_state == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (DIV=4): stimulus queues expected commits,
// a negedge monitor pops one per pc_en pulse and checks cycle, pc and retired.
module tb_cpu_run_ctrl;
   import cpu_seq_pkg::*;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
   logic [7:0]  pc = 8'h00, instruction = 8'h00, bp_addr = 8'h00;
   logic        bp_valid = 1'b0;
   logic        pc_en, at_bp;
   logic [1:0]  state;
   logic [15:0] retired;

   logic        pc_ld = 1'b0;
   logic [7:0]  pc_ld_val = 8'h00;
   int          cyc = 0;
   int          n_pass = 0, n_tot = 0;

   typedef struct {
      int          cyc;
      logic [7:0]  pc;
      logic [15:0] ret;
   } exp_t;
   exp_t sb[$];

   cpu_run_ctrl #(.DIV(DIV), .CW(25), .HALT_INSN(8'hFF)) dut (
      .clk         (clk),
      .reset       (reset),
      .run_req     (run_req),
      .step_req    (step_req),
      .halt_req    (halt_req),
      .pc          (pc),
      .instruction (instruction),
      .bp_addr     (bp_addr),
      .bp_valid    (bp_valid),
      .pc_en       (pc_en),
      .state       (state),
      .retired     (retired),
      .at_bp       (at_bp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stand-in: PC advances on each commit, or loads for a new test.
   always @(posedge clk) begin
      if (pc_ld)      pc <= pc_ld_val;
      else if (pc_en) pc <= pc + 8'd1;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input int c, input logic [7:0] p, input logic [15:0] r);
      exp_t e;
      e.cyc = c; e.pc = p; e.ret = r;
      sb.push_back(e);
   endtask

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (pc_en) begin
         if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_commit: pc_en=1 at cycle %0d pc=%0h, none expected", cyc, pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_cycle", cyc, e.cyc);
            chk("commit_pc", pc, e.pc);
            chk("commit_retired", retired, e.ret);
         end
      end
   end

   initial begin
      int k, s, b, r, h, g, t;
      logic [7:0]  hp_pc;
      logic [15:0] hp_ret;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", state, ST_IDLE);
      chk("reset_pc_en", pc_en, 0);
      chk("reset_retired", retired, 0);
      chk("reset_at_bp", at_bp, 0);
      pc_ld = 1'b1; pc_ld_val = 8'h10;
      reset = 1'b0;
      go_to(cyc + 1);
      pc_ld = 1'b0;
      go_to(cyc + 2);

      // Basic run: commits 4, 8, 12 cycles after the capturing edge
      k = cyc;
      run_req = 1'b1;
      push(k + 5, 8'h10, 16'd0);
      push(k + 9, 8'h11, 16'd1);
      push(k + 13, 8'h12, 16'd2);
      go_to(k + 2); run_req = 1'b0;
      go_to(k + 6); chk("run_state", state, ST_RUN);
      go_to(k + 14); chk("run_retired", retired, 3);
      halt_req = 1'b1;
      go_to(k + 15); chk("halt_to_idle", state, ST_IDLE);
      halt_req = 1'b0;
      go_to(k + 17);

      // Single step with step_req held high
      s = cyc;
      step_req = 1'b1;
      push(s + 1, 8'h13, 16'd3);
      go_to(s + 8);
      chk("step_state", state, ST_IDLE);
      chk("step_retired", retired, 4);
      step_req = 1'b0;

      // Breakpoint at 8'h05, running from pc=3
      pc_ld = 1'b1; pc_ld_val = 8'h03; bp_addr = 8'h05; bp_valid = 1'b1;
      go_to(cyc + 1); pc_ld = 1'b0;
      go_to(cyc + 1);
      b = cyc;
      run_req = 1'b1;
      push(b + 5, 8'h03, 16'd4);
      push(b + 9, 8'h04, 16'd5);
      go_to(b + 2); run_req = 1'b0;
      go_to(b + 13);
      chk("bp_state", state, ST_BREAK);
      chk("bp_at_bp", at_bp, 1);
      bp_valid = 1'b0;
      go_to(b + 16);
      chk("bp_hold_state", state, ST_BREAK);
      chk("bp_retired", retired, 6);
      bp_valid = 1'b1;

      // Resume from BREAK: pc=5 commits, no re-break
      r = cyc;
      run_req = 1'b1;
      push(r + 5, 8'h05, 16'd6);
      push(r + 9, 8'h06, 16'd7);
      go_to(r + 2); run_req = 1'b0;
      go_to(r + 6); chk("resume_at_bp", at_bp, 0);

      // Halt in the commit cycle gates pc_en and forces IDLE
      go_to(r + 13);
      halt_req = 1'b1;
      #1;
      chk("halt_gate_pc_en", pc_en, 0);
      go_to(r + 14);
      chk("halt_gate_state", state, ST_IDLE);
      chk("halt_gate_retired", retired, 8);
      run_req = 1'b1;
      go_to(r + 18);
      chk("halt_blocks_run", state, ST_IDLE);
      halt_req = 1'b0;
      go_to(r + 22);
      chk("run_edge_discarded", state, ST_IDLE);
      run_req = 1'b0; bp_valid = 1'b0;
      go_to(cyc + 1);

      // Halt opcode via step, then via run
      instruction = 8'hFF;
      h = cyc;
      step_req = 1'b1;
`ifndef HALT_OPCODE_EN
      push(h + 1, 8'h07, 16'd8);
`endif
      go_to(h + 3);
      step_req = 1'b0;
      chk("haltop_step_state", state, ST_IDLE);
`ifdef HALT_OPCODE_EN
      chk("haltop_step_retired", retired, 8);
      hp_pc = 8'h07; hp_ret = 16'd8;
`else
      chk("haltop_step_retired", retired, 9);
      hp_pc = 8'h08; hp_ret = 16'd9;
`endif
      g = cyc;
      run_req = 1'b1;
`ifndef HALT_OPCODE_EN
      push(g + 5, hp_pc, hp_ret);
`endif
      go_to(g + 2); run_req = 1'b0;
      go_to(g + 6);
`ifdef HALT_OPCODE_EN
      chk("haltop_run_state", state, ST_IDLE);
      chk("haltop_run_retired", retired, hp_ret);
`else
      chk("haltop_run_state", state, ST_RUN);
      chk("haltop_run_retired", retired, hp_ret + 16'd1);
`endif
      halt_req = 1'b1;
      go_to(g + 7);
      halt_req = 1'b0; instruction = 8'h00;

      // Saturation: preload retired just below the limit
      pc_ld = 1'b1; pc_ld_val = 8'h20;
      @(negedge clk);
      force dut.r_retired = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut.r_retired;
      pc_ld = 1'b0;
      go_to(cyc + 1);
      t = cyc;
      run_req = 1'b1;
      push(t + 5, 8'h20, 16'hFFFD);
      push(t + 9, 8'h21, 16'hFFFE);
      push(t + 13, 8'h22, 16'hFFFF);
      push(t + 17, 8'h23, 16'hFFFF);
      go_to(t + 2); run_req = 1'b0;
      go_to(t + 18);
      chk("sat_retired", retired, 16'hFFFF);

      // Async reset in a commit cycle
      go_to(t + 21);
      #1;
      chk("pre_reset_pc_en", pc_en, 1);
      reset = 1'b1;
      #1;
      chk("async_reset_pc_en", pc_en, 0);
      chk("async_reset_retired", retired, 0);
      chk("async_reset_state", state, ST_IDLE);
      chk("async_reset_at_bp", at_bp, 0);
      go_to(cyc + 2);
      reset = 1'b0;
      go_to(cyc + 6);
      chk("post_reset_state", state, ST_IDLE);
      chk("pending_commits", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
